// File: rtl/seq_mul_pipe_if.sv
// rtl/seq_mul_pipe_if.sv - operand/result handshake bundle for seq_mul_pipe
interface seq_mul_pipe_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
);
    localparam int CW = $clog2(WIDTH / STEP + 2);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   o;
    logic                 busy;
    logic [CW-1:0]        lat;

    // Producer/consumer side: issues operands and accepts results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, o, busy, lat
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, o, busy, lat
    );
endinterface

// File: rtl/seq_mul_pipe.sv
// rtl/seq_mul_pipe.sv - sequential shift-and-add multiplier, STEP bits/cycle; SEQ_MUL_CT_TIME_EN selects fixed latency
module seq_mul_pipe #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    seq_mul_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH / STEP + 2);
    localparam int SL = $clog2(STEP);
`ifdef SEQ_MUL_CT_TIME_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / STEP - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_lat;
    logic                 w_iter;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_add;
    logic [CW+1:0]        w_shamt;

    // Partial product of the low STEP multiplier bits, placed at bit cnt*STEP.
    // STEP is a power of two, so the multiply by STEP is a left shift.
    assign w_pp    = {{WIDTH{1'b0}}, r_a} * {{(2*WIDTH-STEP){1'b0}}, r_b[STEP-1:0]};
    assign w_shamt = {2'b00, r_cnt} << SL;
    assign w_add   = w_pp << w_shamt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and iterate enable
    always_comb begin
        w_next = r_state;
        w_iter = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
`ifdef SEQ_MUL_CT_TIME_EN
                // Operand-independent: always WIDTH/STEP iterations
                w_iter = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_next = S_DONE;
                end
`else
                // Stop once no set multiplier bits remain (or multiplicand is zero);
                // the check itself costs one RUN cycle.
                if ((r_a == '0) || (r_b == '0)) begin
                    w_next = S_DONE;
                end else begin
                    w_iter = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, accumulate, shift and cycle accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_lat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_lat <= '0;
                    end
                end
                S_RUN: begin
                    r_lat <= r_lat + CW'(1);
                    if (w_iter) begin
                        r_acc <= r_acc + w_add;
                        r_b   <= r_b >> STEP;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode purely from registers
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.o         = r_acc;
    assign bus.lat       = r_lat;
endmodule

// File: tb/tb_seq_mul_pipe.sv
// tb/tb_seq_mul_pipe.sv - scoreboard bench for seq_mul_pipe (two STEP=1 copies, one STEP=2)
module tb_seq_mul_pipe;
    logic clk;
    logic rst;

    logic       in_valid, out_ready;
    logic [7:0] a0, a1, b_s;
    logic       in_valid2;
    logic [7:0] a2, b2;
    logic       bp_rand;

    longint n_tests = 0;
    longint n_fail  = 0;
    longint cyc     = 0;

    typedef struct {
        longint prod;
        longint lat;
        longint cyc;
    } exp_t;

    exp_t q[3][$];
    bit   prev_v[3];

    seq_mul_pipe_if #(.WIDTH(8), .STEP(1)) bus0 ();
    seq_mul_pipe_if #(.WIDTH(8), .STEP(1)) bus1 ();
    seq_mul_pipe_if #(.WIDTH(8), .STEP(2)) bus2 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.a         = a0;
    assign bus0.b         = b_s;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a1;
    assign bus1.b         = b_s;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid  = in_valid2;
    assign bus2.a         = a2;
    assign bus2.b         = b2;
    assign bus2.out_ready = 1'b1;

    seq_mul_pipe #(.WIDTH(8), .STEP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_mul_pipe #(.WIDTH(8), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_mul_pipe #(.WIDTH(8), .STEP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference latency: RUN cycles from the multiplier's bit length
    function automatic longint exp_n(input int x, input int y, input int step);
`ifdef SEQ_MUL_CT_TIME_EN
        return 8 / step;
`else
        int msb;
        if (x == 0 || y == 0) return 1;
        msb = 0;
        for (int i = 0; i < 8; i++) if (((y >> i) & 1) == 1) msb = i;
        return (msb + step) / step + 1;
`endif
    endfunction

    task automatic mon_step(input int id, input logic v, input logic r, input longint o,
                            input longint lat, input logic irdy, input logic bsy);
        exp_t e;
        if (v) begin
            if (q[id].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out[%0d]: got result %0d with empty scoreboard", id, o);
            end else begin
                e = q[id][0];
                if (!prev_v[id]) chk($sformatf("out_valid_cycle[%0d]", id), cyc, e.cyc);
                chk($sformatf("o[%0d]", id), o, e.prod);
                chk($sformatf("lat[%0d]", id), lat, e.lat);
                chk($sformatf("in_ready_in_done[%0d]", id), longint'(irdy), 0);
                chk($sformatf("busy_in_done[%0d]", id), longint'(bsy), 0);
                if (r) void'(q[id].pop_front());
            end
        end
        prev_v[id] = v;
    endtask

    // Monitor: compares every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            mon_step(0, bus0.out_valid, bus0.out_ready, longint'(bus0.o), longint'(bus0.lat),
                     bus0.in_ready, bus0.busy);
            mon_step(1, bus1.out_valid, bus1.out_ready, longint'(bus1.o), longint'(bus1.lat),
                     bus1.in_ready, bus1.busy);
            mon_step(2, bus2.out_valid, bus2.out_ready, longint'(bus2.o), longint'(bus2.lat),
                     bus2.in_ready, bus2.busy);
`ifdef SEQ_MUL_CT_TIME_EN
            chk("copy_out_valid_match", longint'(bus1.out_valid), longint'(bus0.out_valid));
            chk("copy_lat_match", longint'(bus1.lat), longint'(bus0.lat));
`endif
        end
    end

    // Random consumer backpressure
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] y);
        bit got = 0;
        longint n;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        a0 = x0;
        a1 = x1;
        b_s = y;
        in_valid = 1'b1;
        n = exp_n(int'(x0), int'(y), 1);
        q[0].push_back('{longint'(x0) * longint'(y), n, cyc + 1 + n});
        n = exp_n(int'(x1), int'(y), 1);
        q[1].push_back('{longint'(x1) * longint'(y), n, cyc + 1 + n});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue2(input logic [7:0] x, input logic [7:0] y);
        bit got = 0;
        longint n;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus2.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("issue2_timeout", 0, 1);
            return;
        end
        a2 = x;
        b2 = y;
        in_valid2 = 1'b1;
        n = exp_n(int'(x), int'(y), 2);
        q[2].push_back('{longint'(x) * longint'(y), n, cyc + 1 + n});
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, rx;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        bp_rand = 1'b0;
        a0 = '0; a1 = '0; b_s = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", longint'(bus0.in_ready), 1);
        chk("reset_out_valid", longint'(bus0.out_valid), 0);
        chk("reset_busy", longint'(bus0.busy), 0);
        chk("reset_o", longint'(bus0.o), 0);
        chk("reset_lat", longint'(bus0.lat), 0);

        // Directed cases
        issue(8'd3, 8'd3, 8'd5);
        issue(8'd0, 8'd0, 8'd200);
        issue(8'd255, 8'd255, 8'd255);
        issue(8'd0, 8'd0, 8'd0);
        issue(8'd1, 8'd1, 8'd128);
        issue(8'd200, 8'd200, 8'd1);

        // Backpressure with new operands presented during DONE
        for (int t = 0; t < 300 && q[0].size() != 0; t++) @(negedge clk);
        out_ready = 1'b0;
        issue(8'd3, 8'd3, 8'd5);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus0.out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_reached_done", longint'(seen), 1);
        a0 = 8'd9; a1 = 8'd9; b_s = 8'd9;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", longint'(bus0.in_ready), 1);
        chk("bp_release_out_valid", longint'(bus0.out_valid), 0);
        q[0].push_back('{81, exp_n(9, 9, 1), cyc + 1 + exp_n(9, 9, 1)});
        q[1].push_back('{81, exp_n(9, 9, 1), cyc + 1 + exp_n(9, 9, 1)});
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Reset in RUN cycle 2 discards the operation
        issue(8'd7, 8'd7, 8'd9);
        @(posedge clk);
        @(negedge clk);
        q[0].delete();
        q[1].delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_in_ready", longint'(bus0.in_ready), 1);
        chk("midrun_rst_out_valid", longint'(bus0.out_valid), 0);
        chk("midrun_rst_busy", longint'(bus0.busy), 0);
        chk("midrun_rst_o", longint'(bus0.o), 0);
        chk("midrun_rst_lat", longint'(bus0.lat), 0);
        issue(8'd7, 8'd7, 8'd9);

        // Randomised traffic; in constant-time builds copy 1 gets a different multiplicand
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : (8'($urandom) >> $urandom_range(0, 7));
`ifdef SEQ_MUL_CT_TIME_EN
            rx = ra ^ 8'($urandom_range(1, 255));
`else
            rx = ra;
`endif
            issue(ra, rx, rb);
        end
        bp_rand = 1'b0;
        #3 out_ready = 1'b1;

        // STEP=2 copy
        issue2(8'd200, 8'd150);
        issue2(8'd0, 8'd77);
        issue2(8'd255, 8'd255);
        issue2(8'd1, 8'd1);
        issue2(8'd5, 8'd0);
        for (int i = 0; i < 15; i++) begin
            issue2(8'($urandom), 8'($urandom) >> $urandom_range(0, 7));
        end

        seen = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) begin
                seen = 1;
                break;
            end
        end
        chk("scoreboard_drained", longint'(seen), 1);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
